// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: serial line and oversample tick in, frame result and status out.
interface uart_rx_cfg_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic            stick;
    logic            rxtick;
    logic [DBIT-1:0] out;
    logic            perr;
    logic            ferr;
    logic            brk;
    logic            busy;

    modport master (
        output rx, stick,
        input  rxtick, out, perr, ferr, brk, busy
    );

    modport slave (
        input  rx, stick,
        output rxtick, out, perr, ferr, brk, busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised line input, mid-bit sampling on the oversample
// tick, optional parity, and parity/framing/break status latched at the end of each frame.
module uart_rx_cfg #(
    parameter int DBIT       = 8,
    parameter int OVS        = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic          clk,
    input  logic          rstn,
    uart_rx_cfg_if.slave  bus
);
    localparam int TW = $clog2((OVS > SB_TICK) ? OVS : SB_TICK);
    localparam int BW = $clog2(DBIT);

    localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_BIT  = TW'(OVS - 1);
    localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);
    localparam bit            HAS_PAR = (PARITY_EN != 0);
    localparam bit            PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   tick_q;
    logic [BW-1:0]   bit_q;
    logic [DBIT-1:0] shift_q;
    logic            p_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic            rxtick_q;
    logic [DBIT-1:0] out_q;
    logic            perr_q;
    logic            ferr_q;
    logic            brk_q;
    logic            busy_q;

    logic [DBIT-1:0] shift_d;
    logic            perr_d;
    logic            brk_d;

    assign shift_d = {rx_s_q, shift_q[DBIT-1:1]};
    assign perr_d  = HAS_PAR && ((^shift_q ^ p_q) != PAR_ODD);
    // Break needs every sampled bit low, including the stop bit currently on rx_s.
    assign brk_d   = (shift_q == '0) && (!HAS_PAR || !p_q) && !rx_s_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            p_q       <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rxtick_q  <= 1'b0;
            out_q     <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            rxtick_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        tick_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bus.stick) begin
                        if (tick_q == T_HALF) begin
                            // Still low at mid start bit: a real frame; otherwise a glitch.
                            if (!rx_s_q) begin
                                state_q <= DATA;
                                tick_q  <= '0;
                                bit_q   <= '0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (bus.stick) begin
                        if (tick_q == T_BIT) begin
                            tick_q  <= '0;
                            shift_q <= shift_d;
                            if (bit_q == B_LAST) begin
                                state_q <= HAS_PAR ? PARITY : STOP;
                            end else begin
                                bit_q <= bit_q + BW'(1);
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bus.stick) begin
                        if (tick_q == T_BIT) begin
                            p_q     <= rx_s_q;
                            tick_q  <= '0;
                            state_q <= STOP;
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
                STOP: begin
                    if (bus.stick) begin
                        if (tick_q == T_STOP) begin
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                            rxtick_q <= 1'b1;
                            out_q    <= shift_q;
                            perr_q   <= perr_d;
                            ferr_q   <= !rx_s_q;
                            brk_q    <= brk_d;
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rxtick = rxtick_q;
    assign bus.out    = out_q;
    assign bus.perr   = perr_q;
    assign bus.ferr   = ferr_q;
    assign bus.brk    = brk_q;
    assign bus.busy   = busy_q;
endmodule
